// File: rtl/register_dump_tx_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | register_dump_tx_pkg : state encoding and byte-order helper for the dump   |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
package register_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    NEXT = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [7:0]  HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned REG_WIDTH           = 32;

  // Bit offset of data byte j: registers in ascending order, MSB first within each.
  function automatic int unsigned byte_offset(int unsigned j, int unsigned bpr);
    return REG_WIDTH * (j / bpr) + 8 * (bpr - 1 - (j % bpr));
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_dump_tx_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | register_dump_tx_if : byte handshake between the dump reader and UART TX   |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
interface register_dump_tx_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done
  );

endinterface
`default_nettype wire

// File: rtl/register_dump_tx_mux.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dump_byte_mux : combinational pick of data byte j from the snapshot        |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module dump_byte_mux
  import register_dump_tx_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned BYTES_PER_REG = 4
) (
  input  logic [NUM_REGS*REG_WIDTH-1:0] snapshot,
  input  logic [15:0]                   byte_idx,
  output logic [7:0]                    byte_o
);

  localparam int unsigned NUM_BYTES = NUM_REGS * BYTES_PER_REG;

  logic [7:0] w_bytes [NUM_BYTES];

  for (genvar j = 0; j < NUM_BYTES; j++) begin : g_bytes
    assign w_bytes[j] = snapshot[byte_offset(j, BYTES_PER_REG) +: 8];
  end

  // Out-of-range indices (e.g. while the header is current) read as zero.
  always_comb begin
    byte_o = 8'h00;
    for (int j = 0; j < NUM_BYTES; j++) begin
      if (byte_idx == 16'(j)) begin
        byte_o = w_bytes[j];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_dump_tx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | register_dump_tx : snapshots the register dump bus and streams it to UART  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module register_dump_tx
  import register_dump_tx_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned BYTES_PER_REG = 4,
  parameter int unsigned SEND_HEADER   = 1,
  parameter logic [7:0]  HEADER_BYTE   = HEADER_BYTE_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_REGS*REG_WIDTH-1:0] registros,
  register_dump_tx_if.master            tx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NUM_BYTES = NUM_REGS * BYTES_PER_REG;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_BYTES + SEND_HEADER - 1);

  state_t                        state_q, state_d;
  logic [15:0]                   idx_q, idx_d;
  logic [NUM_REGS*REG_WIDTH-1:0] snap_q, snap_d;
  logic [7:0]                    tx_data_q, tx_data_d;
  logic                          tx_start_q, tx_start_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [15:0] w_data_idx;
  logic [7:0]  w_data_byte;
  logic [7:0]  w_cur_byte;

  assign w_data_idx = idx_q - 16'(SEND_HEADER);

  dump_byte_mux #(
    .NUM_REGS      (NUM_REGS),
    .BYTES_PER_REG (BYTES_PER_REG)
  ) u_byte_mux (
    .snapshot (snap_q),
    .byte_idx (w_data_idx),
    .byte_o   (w_data_byte)
  );

  assign w_cur_byte = ((SEND_HEADER != 0) && (idx_q == 16'd0)) ? HEADER_BYTE : w_data_byte;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          snap_d  = registros;
          busy_d  = 1'b1;
          idx_d   = 16'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx.tx_busy) begin
          tx_data_d  = w_cur_byte;
          tx_start_d = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx.tx_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        // done/busy are registered here so they are visible during FIN.
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = SEND;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel outranks every other transition; the UART finishes its byte alone.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 16'd0;
      snap_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_start = tx_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_register_dump_tx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_register_dump_tx : directed scoreboard bench for register_dump_tx       |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_register_dump_tx;

  localparam int NREG     = 32;
  localparam int UART_LAT = 10;
  localparam int GAP      = UART_LAT + 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start0  = 1'b0;
  logic abort0  = 1'b0;
  logic start1  = 1'b0;
  logic abort1  = 1'b0;
  logic [NREG*32-1:0] regs0 = '0;
  logic [NREG*32-1:0] regs1 = '0;
  logic busy0, done0, busy1, done1;

  register_dump_tx_if uif0 ();
  register_dump_tx_if uif1 ();

  register_dump_tx dut0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start0),
    .abort     (abort0),
    .registros (regs0),
    .tx        (uif0),
    .busy      (busy0),
    .done      (done0)
  );

  register_dump_tx #(.SEND_HEADER(0)) dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start1),
    .abort     (abort1),
    .registros (regs1),
    .tx        (uif1),
    .busy      (busy1),
    .done      (done1)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] sb  [2][$];
  logic [7:0] cap [2][$];
  int ucnt [2];
  int n_start [2];
  int n_done [2];
  int first_start [2];
  int last_start [2];
  int gap_bad [2];
  bit force_busy [2];
  bit scramble0 = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_busy();
    uif0.tx_busy = force_busy[0] | (ucnt[0] > 0);
    uif1.tx_busy = force_busy[1] | (ucnt[1] > 0);
  endtask

  task automatic clear_stats(int i);
    n_start[i]     = 0;
    n_done[i]      = 0;
    first_start[i] = -1;
    last_start[i]  = 0;
    gap_bad[i]     = 0;
    cap[i].delete();
  endtask

  // Reference byte stream: optional header, then each register MSB first.
  task automatic push_exp(int i, logic [NREG*32-1:0] regs, bit hdr);
    if (hdr) sb[i].push_back(8'hA5);
    for (int r = 0; r < NREG; r++)
      for (int b = 0; b < 4; b++)
        sb[i].push_back(regs[r*32 + 24 - 8*b +: 8]);
  endtask

  // One cycle: sample at negedge, run the UART model, drive next inputs.
  task automatic tick();
    logic       st [2];
    logic [7:0] dt [2];
    logic       dn [2];
    logic       bz [2];
    logic       td [2];
    @(negedge clock);
    cyc++;
    st[0] = uif0.tx_start; dt[0] = uif0.tx_data; dn[0] = done0; bz[0] = busy0;
    st[1] = uif1.tx_start; dt[1] = uif1.tx_data; dn[1] = done1; bz[1] = busy1;
    for (int i = 0; i < 2; i++) begin
      td[i] = 1'b0;
      if (st[i] === 1'b1) begin
        n_start[i]++;
        cap[i].push_back(dt[i]);
        if (first_start[i] < 0) first_start[i] = cyc;
        else if (cyc - last_start[i] != GAP) gap_bad[i]++;
        last_start[i] = cyc;
        if (sb[i].size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("tx_data", {24'd0, dt[i]}, {24'd0, sb[i].pop_front()});
        ucnt[i] = UART_LAT;
      end else if (ucnt[i] > 0) begin
        ucnt[i]--;
        if (ucnt[i] == 0) td[i] = 1'b1;
      end
      if (dn[i] === 1'b1) begin
        n_done[i]++;
        chk("busy_with_done", {31'd0, bz[i]}, 32'd0);
      end
    end
    uif0.tx_done = td[0];
    uif1.tx_done = td[1];
    drive_busy();
    if (scramble0)
      for (int k = 0; k < NREG; k++) regs0[k*32 +: 32] = $urandom;
  endtask

  task automatic wait_done(int i, int budget);
    int n0 = n_done[i];
    int k  = 0;
    while (n_done[i] == n0 && k < budget) begin
      tick();
      k++;
    end
    if (n_done[i] == n0) chk($sformatf("timeout_done%0d", i), 32'd0, 32'd1);
  endtask

  task automatic wait_starts(int i, int n, int budget);
    int k = 0;
    while (n_start[i] < n && k < budget) begin
      tick();
      k++;
    end
    chk("reach_byte", n_start[i], n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    uif0.tx_busy = 1'b0; uif0.tx_done = 1'b0;
    uif1.tx_busy = 1'b0; uif1.tx_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ucnt[i] = 0;
      force_busy[i] = 1'b0;
      clear_stats(i);
    end
    for (int k = 0; k < NREG; k++) begin
      regs0[k*32 +: 32] = k;
      regs1[k*32 +: 32] = k;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_tx_data",  {24'd0, uif0.tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, uif0.tx_start}, 32'd0);
    chk("rst_busy",     {31'd0, busy0}, 32'd0);
    chk("rst_done",     {31'd0, done0}, 32'd0);
    chk("rst_busy1",    {31'd0, busy1}, 32'd0);
    reset_n = 1'b1;
    tick();

    // start and abort together in IDLE: nothing starts
    start0 = 1'b1; abort0 = 1'b1;
    tick();
    start0 = 1'b0; abort0 = 1'b0;
    chk("start_abort_busy", {31'd0, busy0}, 32'd0);
    repeat (3) tick();
    chk("start_abort_nostart", n_start[0], 0);

    // Full dump of the reset pattern
    clear_stats(0);
    push_exp(0, regs0, 1'b1);
    start0 = 1'b1; t0 = cyc;
    tick();
    start0 = 1'b0;
    chk("busy_after_start", {31'd0, busy0}, 32'd1);
    wait_done(0, 3000);
    chk("t1_latency", first_start[0] - t0, 2);
    chk("t1_nbytes", n_start[0], 129);
    chk("t1_ndone", n_done[0], 1);
    chk("t1_gap", gap_bad[0], 0);
    chk("t1_first", {24'd0, cap[0][0]}, 32'h0000_00A5);
    chk("t1_last",  {24'd0, cap[0][128]}, 32'h0000_001F);
    chk("t1_sb_empty", sb[0].size(), 0);
    tick();
    chk("t1_idle_busy", {31'd0, busy0}, 32'd0);

    // Snapshot isolation: bus scrambled every cycle after start
    regs0[5*32 +: 32] = 32'hDEADBEEF;
    clear_stats(0);
    push_exp(0, regs0, 1'b1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    scramble0 = 1'b1;
    wait_done(0, 3000);
    scramble0 = 1'b0;
    chk("t2_nbytes", n_start[0], 129);
    chk("t2_b21", {24'd0, cap[0][21]}, 32'h0000_00DE);
    chk("t2_b22", {24'd0, cap[0][22]}, 32'h0000_00AD);
    chk("t2_b23", {24'd0, cap[0][23]}, 32'h0000_00BE);
    chk("t2_b24", {24'd0, cap[0][24]}, 32'h0000_00EF);
    tick();

    // UART busy for 50 cycles after start
    for (int k = 0; k < NREG; k++) regs0[k*32 +: 32] = k;
    clear_stats(0);
    push_exp(0, regs0, 1'b1);
    force_busy[0] = 1'b1;
    drive_busy();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (49) tick();
    chk("t3_held", n_start[0], 0);
    force_busy[0] = 1'b0;
    drive_busy();
    t0 = cyc;
    wait_done(0, 3000);
    chk("t3_release_lat", first_start[0] - t0, 1);
    chk("t3_first", {24'd0, cap[0][0]}, 32'h0000_00A5);
    chk("t3_nbytes", n_start[0], 129);
    tick();

    // Abort during WAIT of byte 40
    clear_stats(0);
    push_exp(0, regs0, 1'b1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_starts(0, 41, 1000);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    chk("t4_busy", {31'd0, busy0}, 32'd0);
    chk("t4_tx_start", {31'd0, uif0.tx_start}, 32'd0);
    sb[0].delete();
    repeat (40) tick();
    chk("t4_nstart", n_start[0], 41);
    chk("t4_ndone", n_done[0], 0);
    clear_stats(0);
    push_exp(0, regs0, 1'b1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(0, 3000);
    chk("t4_restart_n", n_start[0], 129);
    chk("t4_restart_hdr", {24'd0, cap[0][0]}, 32'h0000_00A5);
    tick();

    // Asynchronous reset during byte 10
    for (int k = 0; k < NREG; k++) regs0[k*32 +: 32] = 32'hA0B0C0D0 ^ k;
    clear_stats(0);
    push_exp(0, regs0, 1'b1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_starts(0, 11, 500);
    tick();
    chk("t5_pre_data", {24'd0, uif0.tx_data}, 32'h0000_00B0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_tx_data",  {24'd0, uif0.tx_data}, 32'd0);
    chk("t5_tx_start", {31'd0, uif0.tx_start}, 32'd0);
    chk("t5_busy",     {31'd0, busy0}, 32'd0);
    chk("t5_done",     {31'd0, done0}, 32'd0);
    tick();
    reset_n = 1'b1;
    sb[0].delete();
    repeat (30) tick();
    chk("t5_idle_busy", {31'd0, busy0}, 32'd0);
    chk("t5_nstart", n_start[0], 11);
    chk("t5_ndone", n_done[0], 0);

    // No header, start held high: back-to-back dumps
    clear_stats(1);
    push_exp(1, regs1, 1'b0);
    start1 = 1'b1;
    wait_done(1, 3000);
    push_exp(1, regs1, 1'b0);
    chk("t6_nbytes", n_start[1], 128);
    chk("t6_first", {24'd0, cap[1][0]}, 32'd0);
    chk("t6_last",  {24'd0, cap[1][127]}, 32'h0000_001F);
    tick();
    tick();
    chk("t6_restart_busy", {31'd0, busy1}, 32'd1);
    start1 = 1'b0;
    clear_stats(1);
    wait_done(1, 3000);
    chk("t6_second_n", n_start[1], 128);
    chk("t6_sb_empty", sb[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
